instr_encoder: RTL and testbench

//  Inverse of the control-unit decoder: accepts instruction fields (class, rd, rs1, rs2, funct3, funct7, imm)

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/instr_pack.sv | 52 +++++
 rtl/instr_encoder.sv | 102 ++++++++++
 tb/tb_instr_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: opcodes, instruction classes and
// immediate range limits used by the encoder and the control unit.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5
  } instr_class_e;

  // 12-bit immediates (I/LOAD/STORE) and 13-bit branch offsets
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  function automatic logic imm_in_range(input logic signed [20:0] imm, input int lo, input int hi);
    return (int'(imm) >= lo) && (int'(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction class plus fields -> 32-bit RV32I word
// and an illegal flag for out-of-range immediates or unknown classes.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the format for the class and check its immediate constraints
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_class_e'(cls))
      CLS_R: begin
        word = {funct7, rs2, rs1, funct3, rd, OP_R};
      end
      CLS_I: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_I};
        illegal = !imm_in_range($signed(imm), IMM12_MIN, IMM12_MAX);
      end
      CLS_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        illegal = !imm_in_range($signed(imm), IMM12_MIN, IMM12_MAX);
      end
      CLS_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        illegal = !imm_in_range($signed(imm), IMM12_MIN, IMM12_MAX);
      end
      CLS_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        illegal = !imm_in_range($signed(imm), IMM13_MIN, IMM13_MAX) || imm[0];
      end
      CLS_JAL: begin
        // the full 21-bit range is encodable, only odd offsets are rejected
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = imm[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts instruction fields over valid/ready, encodes them
// and writes consecutive words into instruction memory, then releases the core.
//
// state   | meaning
// LOAD    | accepting instructions, writing words at wr_ptr
// DONE    | in_last seen; inputs refused until rst_n/clear
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              prog_done,
  output logic              cpu_rst_n
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_e          state;
  logic [ADDR_W:0] wr_ptr;
  logic            done_d1;
  logic [31:0]     pack_word;
  logic            pack_illegal;
  logic            xfer;

  // reset and clear both block acceptance in the cycle they are asserted
  assign in_ready   = rst_n && !clear && (state == ST_LOAD) && (wr_ptr < DEPTH_V);
  assign xfer       = in_valid && in_ready;
  assign word_count = wr_ptr;
  assign cpu_rst_n  = prog_done;

  instr_pack u_pack (
    .cls     (in_class),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // FSM, write pointer, registered memory write port, error counter and done flag
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state      <= ST_LOAD;
      wr_ptr     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      done_d1    <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      err_pulse <= 1'b0;
      // done_d1 delays the release so the last write has completed first
      done_d1   <= (state == ST_DONE);
      prog_done <= prog_done | done_d1;
      if (xfer) begin
        if (pack_illegal) begin
          err_pulse <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_ptr[ADDR_W-1:0];
          imem_wdata <= pack_word;
          wr_ptr     <= wr_ptr + 1'b1;
        end
        if (in_last) state <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder with a field-placement
// reference model and a cycle-level expectation of every output.
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n, clear, in_valid, in_ready, in_last;
  logic [2:0]        in_class, in_funct3;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [6:0]        in_funct7;
  logic [20:0]       in_imm;
  logic              imem_we, err_pulse, prog_done, cpu_rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic [ERR_W-1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr = 0, m_err = 0, m_timer = 0;
  bit          m_done = 0, m_pd = 0;
  bit          e_we = 0, e_ep = 0, e_data_chk = 0;
  int          e_addr = 0;
  logic [31:0] e_wdata = '0;

  int bnd [10] = '{-4097, -4096, -4094, -2049, -2048, 2047, 2048, 4094, 4095, 4096};

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .prog_done  (prog_done),
    .cpu_rst_n  (cpu_rst_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // places the low 'width' bits of v at bit position pos
  function automatic logic [31:0] fld(input int v, input int width, input int pos);
    return (32'(v) & ((32'd1 << width) - 32'd1)) << pos;
  endfunction

  // returns {illegal, word}
  function automatic logic [32:0] ref_encode(input int cls, input int rd, input int rs1, input int rs2,
                                             input int f3, input int f7, input int imm);
    logic [31:0] w;
    logic [31:0] regs;
    bit          bad;
    w    = '0;
    bad  = 0;
    regs = fld(f3, 3, 12) | fld(rs1, 5, 15);
    case (cls)
      0: w = fld(51, 7, 0) | fld(rd, 5, 7) | regs | fld(rs2, 5, 20) | fld(f7, 7, 25);
      1, 2: begin
        w   = fld((cls == 1) ? 19 : 3, 7, 0) | fld(rd, 5, 7) | regs | fld(imm, 12, 20);
        bad = (imm < -2048) || (imm > 2047);
      end
      3: begin
        w   = fld(35, 7, 0) | fld(imm, 5, 7) | regs | fld(rs2, 5, 20) | fld(imm >>> 5, 7, 25);
        bad = (imm < -2048) || (imm > 2047);
      end
      4: begin
        w   = fld(99, 7, 0) | fld(imm >>> 11, 1, 7) | fld(imm >>> 1, 4, 8) | regs
            | fld(rs2, 5, 20) | fld(imm >>> 5, 6, 25) | fld(imm >>> 12, 1, 31);
        bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
      end
      5: begin
        w   = fld(111, 7, 0) | fld(rd, 5, 7) | fld(imm >>> 12, 8, 12) | fld(imm >>> 11, 1, 20)
            | fld(imm >>> 1, 10, 21) | fld(imm >>> 20, 1, 31);
        bad = (imm % 2 != 0);
      end
      default: bad = 1;
    endcase
    return {bad, w};
  endfunction

  task automatic drive(input bit v, input int cls, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input int imm, input bit last);
    in_valid  = v;
    in_class  = 3'(cls);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 21'(imm);
    in_last   = last;
  endtask

  // one clock: predict, advance, compare
  task automatic cycle();
    bit          exp_ready;
    logic [32:0] enc;
    #1;
    exp_ready = rst_n && !clear && !m_done && (m_ptr < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (!rst_n || clear) begin
      m_ptr = 0; m_err = 0; m_timer = 0; m_done = 0; m_pd = 0;
      e_we = 0; e_ep = 0; e_addr = 0; e_wdata = '0; e_data_chk = 1;
    end else begin
      e_we = 0; e_ep = 0; e_data_chk = 0;
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) m_pd = 1;
      end
      if (in_valid && exp_ready) begin
        enc = ref_encode(int'(in_class), int'(in_rd), int'(in_rs1), int'(in_rs2),
                         int'(in_funct3), int'(in_funct7), int'($signed(in_imm)));
        if (enc[32]) begin
          e_ep = 1;
          if (m_err < 255) m_err++;
        end else begin
          e_we = 1; e_data_chk = 1;
          e_addr = m_ptr; e_wdata = enc[31:0];
          m_ptr++;
        end
        if (in_last) begin
          m_done  = 1;
          m_timer = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    check("imem_we", 32'(imem_we), 32'(e_we));
    check("err_pulse", 32'(err_pulse), 32'(e_ep));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("word_count", 32'(word_count), 32'(m_ptr));
    check("prog_done", 32'(prog_done), 32'(m_pd));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_pd));
    if (e_data_chk) begin
      check("imem_addr", 32'(imem_addr), 32'(e_addr));
      check("imem_wdata", imem_wdata, e_wdata);
    end
  endtask

  task automatic drive_random(input bit last);
    int imm, sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       imm = bnd[$urandom_range(0, 9)];
      1:       imm = int'($urandom_range(0, 8191)) - 4096;
      2:       imm = int'($signed(21'($urandom)));
      default: imm = 2 * (int'($urandom_range(0, 2047)) - 1024);
    endcase
    drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 127)), imm, last);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // ADD x3, x1, x2
    drive(1, 0, 3, 1, 2, 0, 0, 0, 0);
    cycle();
    check("add_word", imem_wdata, 32'h002081B3);
    check("add_addr", 32'(imem_addr), 32'd0);

    // clear wins over a simultaneous valid, then ADDI/STORE back-to-back
    drive(1, 1, 1, 0, 0, 0, 0, 5, 0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();
    check("addi_word", imem_wdata, 32'h00500093);
    check("addi_addr", 32'(imem_addr), 32'd0);
    drive(1, 3, 0, 0, 2, 2, 0, 8, 0);
    cycle();
    check("sw_word", imem_wdata, 32'h00202423);
    check("sw_addr", 32'(imem_addr), 32'd1);
    check("sw_we", 32'(imem_we), 32'd1);

    // three rejected instructions
    drive(1, 1, 1, 0, 0, 0, 0, 2048, 0);
    cycle();
    drive(1, 4, 0, 0, 0, 0, 0, 3, 0);
    cycle();
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("illegal_err_cnt", 32'(err_cnt), 32'd3);
    check("illegal_word_count", 32'(word_count), 32'd2);

    // BEQ -4, then JAL x1, 8 as the last instruction
    drive(1, 4, 0, 0, 0, 0, 0, -4, 0);
    cycle();
    check("beq_word", imem_wdata, 32'hFE000EE3);
    drive(1, 5, 1, 0, 0, 0, 0, 8, 1);
    cycle();
    check("jal_word", imem_wdata, 32'h008000EF);
    check("jal_addr", 32'(imem_addr), 32'd3);
    drive(1, 0, 3, 1, 2, 0, 0, 0, 0);
    cycle();
    check("done_not_yet", 32'(prog_done), 32'd0);
    cycle();
    check("done_high", 32'(prog_done), 32'd1);
    check("cpu_rst_n_high", 32'(cpu_rst_n), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    check("done_ignored_wc", 32'(word_count), 32'd4);

    // reset the cycle after a transfer drops the pending write
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1, 0, 3, 1, 2, 0, 0, 0, 0);
    cycle();
    rst_n = 1'b0;
    cycle();
    check("rst_drop_we", 32'(imem_we), 32'd0);
    check("rst_drop_wc", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // random fill to DEPTH, then keep offering legal words
    for (int i = 0; i < 2000 && m_ptr < DEPTH; i++) begin
      drive_random(0);
      cycle();
    end
    drive(1, 0, 1, 2, 3, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("full_word_count", 32'(word_count), 32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);

    // random programs with occasional in_last
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive_random($urandom_range(0, 9) == 0);
      cycle();
    end

    // error counter saturation
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("err_saturate", 32'(err_cnt), 32'd255);

    clear = 1'b1;
    cycle();
    clear = 1'b0;
    #1;
    check("clear_ready", 32'(in_ready), 32'd1);
    check("clear_word_count", 32'(word_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
